// File: rtl/reg_file16.sv
// 16 x 16-bit register file: one write port, two registered read ports, r0 hardwired to zero.
// Define REGFILE_BYPASS_EN for write-first reads on a same-edge collision (read-first otherwise).
module reg_file16 #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WE,
  input  logic [ADDR_W-1:0] WA,
  input  logic [WIDTH-1:0]  WD,
  input  logic [ADDR_W-1:0] RA1,
  input  logic [ADDR_W-1:0] RA2,
  input  logic              HOLD,
  output logic [WIDTH-1:0]  RD1,
  output logic [WIDTH-1:0]  RD2
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] regs [DEPTH];
  logic             write_ok;
  logic [WIDTH-1:0] rd1_next;
  logic [WIDTH-1:0] rd2_next;

  assign write_ok = WE && (WA != '0);

  // Stored value at an address, with r0 forced to zero regardless of array contents.
  function automatic logic [WIDTH-1:0] stored(input logic [ADDR_W-1:0] addr);
    return (addr == '0) ? '0 : regs[addr];
  endfunction

`ifdef REGFILE_BYPASS_EN
  assign rd1_next = (write_ok && (RA1 == WA)) ? WD : stored(RA1);
  assign rd2_next = (write_ok && (RA2 == WA)) ? WD : stored(RA2);
`else
  assign rd1_next = stored(RA1);
  assign rd2_next = stored(RA2);
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      RD1 <= '0;
      RD2 <= '0;
    end else begin
      if (write_ok) begin
        regs[WA] <= WD;
      end
      // Stall freezes only the read outputs; the write port keeps running.
      if (!HOLD) begin
        RD1 <= rd1_next;
        RD2 <= rd2_next;
      end
    end
  end

endmodule
